// File: rtl/mmio_key_in.sv
// mmio_key_in: synchronised, debounced pushbutton input port on the data bus.
// Optional auto-repeat of held keys when KEYIN_REPEAT_EN is defined.
module mmio_key_in #(
  parameter logic [7:0] BASE_ADDR       = 8'hF0,
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         REPEAT_CYCLES   = 12500000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [3:0] iKEY,
  input  logic [7:0] iAddress,
  input  logic       iWe,
  input  logic [7:0] iWData,
  output logic [7:0] oRData,
  output logic       oHit
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    level_q, level_d;
  logic [3:0]    event_q, event_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic          last_vld_q, last_vld_d;
  logic [1:0]    last_idx_q, last_idx_d;

  logic [3:0] pressed;
  logic [3:0] rise;
  logic [3:0] rep_fire;
  logic [3:0] set_evt;
  logic [3:0] clr_evt;
  logic [7:0] off;
  logic       wr_evt;
  logic       wr_last;

  // Two-flop synchroniser; raw keys are active-low.
  always_comb begin
    sync1_d = iKEY;
    sync2_d = sync1_q;
  end

  // Per-key debounce: count while synced value differs from level.
  always_comb begin
    pressed = ~sync2_q;
    level_d = level_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    rise = level_d & ~level_q;
  end

`ifdef KEYIN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt_q [4];
  logic [RW-1:0] rep_cnt_d [4];

  // Repeat timer: restarts on press, fires each period while held.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 4; i++) begin
      rep_cnt_d[i] = '0;
      if (level_q[i] && level_d[i]) begin
        if (rep_cnt_q[i] == REP_MAX) begin
          rep_fire[i] = 1'b1;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + RW'(1);
        end
      end
    end
  end

  // Repeat timer registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 4; i++) rep_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end
`else
  logic [31:0] unused_repeat;
  assign unused_repeat = 32'(REPEAT_CYCLES);
  assign rep_fire = '0;
`endif

  logic unused_wdata;
  assign unused_wdata = ^iWData[7:4];

  // Window decode; offset wraps so the window may sit at the top of the map.
  always_comb begin
    off     = iAddress - BASE_ADDR;
    oHit    = (off < 8'd3);
    wr_evt  = iWe && (off == 8'd1);
    wr_last = iWe && (off == 8'd2);
  end

  // Sticky events and last key; a set always beats a same-cycle clear.
  always_comb begin
    set_evt    = rise | rep_fire;
    clr_evt    = wr_evt ? iWData[3:0] : 4'h0;
    event_d    = (event_q & ~clr_evt) | set_evt;
    last_vld_d = last_vld_q;
    last_idx_d = last_idx_q;
    if (|set_evt) begin
      last_vld_d = 1'b1;
      priority case (1'b1)
        set_evt[0]: last_idx_d = 2'd0;
        set_evt[1]: last_idx_d = 2'd1;
        set_evt[2]: last_idx_d = 2'd2;
        default:    last_idx_d = 2'd3;
      endcase
    end else if (wr_last) begin
      last_vld_d = 1'b0;
      last_idx_d = 2'd0;
    end
  end

  // Zero-latency register read mux.
  always_comb begin
    oRData = 8'h00;
    if (oHit) begin
      case (off[1:0])
        2'd0:    oRData = {4'b0, level_q};
        2'd1:    oRData = {4'b0, event_q};
        2'd2:    oRData = {last_vld_q, 5'b0, last_idx_q};
        default: oRData = 8'h00;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      level_q    <= 4'h0;
      event_q    <= 4'h0;
      last_vld_q <= 1'b0;
      last_idx_q <= 2'd0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      event_q    <= event_d;
      last_vld_q <= last_vld_d;
      last_idx_q <= last_idx_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_mmio_key_in.sv
// tb_mmio_key_in: directed stimulus with a window-based reference model.
// Build with +define+KEYIN_REPEAT_EN to exercise auto-repeat.
module tb_mmio_key_in;

  localparam int D = 4;
  localparam int R = 10;

  logic       clk;
  logic       rst_n;
  logic [3:0] iKEY;
  logic [7:0] iAddress;
  logic       iWe;
  logic [7:0] iWData;
  logic [7:0] oRData;
  logic       oHit;

  int checks = 0;
  int errors = 0;

  mmio_key_in #(
    .BASE_ADDR(8'hF0),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES(R)
  ) dut (
    .iCLK(clk),
    .iRST_N(rst_n),
    .iKEY(iKEY),
    .iAddress(iAddress),
    .iWe(iWe),
    .iWData(iWData),
    .oRData(oRData),
    .oHit(oHit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: level toggles once D consecutive synced samples
  // (raw delayed by two edges) all disagree with it.
  int         n = 0;
  logic [3:0] hist [64];
  logic [3:0] m_lvl = 4'h0;
  logic [3:0] m_evt = 4'h0;
  logic       m_vld = 1'b0;
  logic [1:0] m_idx = 2'd0;
  int         pe [4];

  function automatic logic pr_at(int m, int k);
    if (m <= 2) return 1'b0;
    return hist[(m - 2) % 64][k];
  endfunction

  function automatic logic [8:0] mread(logic [7:0] a);
    case (a)
      8'hF0:   return {1'b1, 4'b0, m_lvl};
      8'hF1:   return {1'b1, 4'b0, m_evt};
      8'hF2:   return {1'b1, m_vld, 5'b0, m_idx};
      default: return 9'h000;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] nl, rise, rep, set, clr;
    logic       diff;
    if (!rst_n) begin
      n = 0; m_lvl = 0; m_evt = 0; m_vld = 0; m_idx = 0;
      for (int k = 0; k < 4; k++) pe[k] = 0;
    end else begin
      n = n + 1;
      hist[n % 64] = ~iKEY;
      nl = m_lvl;
      for (int k = 0; k < 4; k++) begin
        diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (pr_at(n - j, k) == m_lvl[k]) diff = 1'b0;
        if (diff) nl[k] = ~m_lvl[k];
      end
      rise = nl & ~m_lvl;
      rep = 4'h0;
`ifdef KEYIN_REPEAT_EN
      for (int k = 0; k < 4; k++)
        if (m_lvl[k] && nl[k] && ((n - pe[k]) % R == 0)) rep[k] = 1'b1;
`endif
      for (int k = 0; k < 4; k++) if (rise[k]) pe[k] = n;
      set = rise | rep;
      clr = (iWe && iAddress == 8'hF1) ? iWData[3:0] : 4'h0;
      m_evt = (m_evt & ~clr) | set;
      if (set != 0) begin
        m_vld = 1'b1;
        for (int k = 3; k >= 0; k--) if (set[k]) m_idx = 2'(k);
      end else if (iWe && iAddress == 8'hF2) begin
        m_vld = 1'b0;
        m_idx = 2'd0;
      end
      m_lvl = nl;
    end
  end

  // Every-cycle comparison of the addressed register against the model.
  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    e = mread(iAddress);
    checks++;
    if (oHit !== e[8] || oRData !== e[7:0]) begin
      errors++;
      $display("FAIL cmp t=%0t addr %02h got hit %b data %02h exp hit %b data %02h",
               $time, iAddress, oHit, oRData, e[8], e[7:0]);
    end
  end

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    iAddress = a;
    #1;
    checks++;
    if (oRData !== exp) begin
      errors++;
      $display("FAIL %s got %02h exp %02h", nm, oRData, exp);
    end
  endtask

  task automatic hit_chk(input logic [7:0] a, input logic exp, input string nm);
    iAddress = a;
    #1;
    checks++;
    if (oHit !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", nm, oHit, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    iAddress = a;
    iWData = d;
    iWe = 1'b1;
    @(negedge clk);
    iWe = 1'b0;
  endtask

  task automatic cyc(input int c);
    repeat (c) @(negedge clk);
  endtask

  logic [7:0] rep_exp;

  initial begin
    rst_n = 1'b0;
    iKEY = 4'hF;
    iAddress = 8'h00;
    iWe = 1'b0;
    iWData = 8'h00;
`ifdef KEYIN_REPEAT_EN
    rep_exp = 8'h01;
`else
    rep_exp = 8'h00;
`endif
    cyc(2);
    rd(8'hF0, 8'h00, "rst_level");
    rd(8'hF2, 8'h00, "rst_last");
    hit_chk(8'hF0, 1'b1, "rst_hit");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);

    // Clean press of key 1.
    iKEY = 4'b1101;
    cyc(5);
    rd(8'hF0, 8'h00, "press_early");
    cyc(1);
    rd(8'hF0, 8'h02, "press_level");
    rd(8'hF1, 8'h02, "press_event");
    rd(8'hF2, 8'h81, "press_last");
    iKEY = 4'hF;
    cyc(8);
    rd(8'hF1, 8'h02, "release_sticky");
    wr(8'hF0, 8'hFF);
    wr(8'hF1, 8'h0F);
    wr(8'hF2, 8'h00);
    rd(8'hF1, 8'h00, "clr_event");

    // Bounce on key 0: runs of two never qualify.
    for (int c = 0; c < 10; c++) begin
      iKEY[0] = ~iKEY[0];
      cyc(2);
    end
    iKEY = 4'hF;
    cyc(8);
    rd(8'hF0, 8'h00, "bounce_level");
    rd(8'hF1, 8'h00, "bounce_event");
    rd(8'hF2, 8'h00, "bounce_last");

    // W1C racing a new press of key 3.
    iKEY = 4'b1101;
    cyc(6);
    rd(8'hF1, 8'h02, "race_pre");
    iKEY = 4'b0101;
    cyc(5);
    iAddress = 8'hF1;
    iWData = 8'h0F;
    iWe = 1'b1;
    @(negedge clk);
    iWe = 1'b0;
    rd(8'hF1, 8'h08, "race_setwins");
    rd(8'hF2, 8'h83, "race_last");
    wr(8'hF1, 8'h08);
    rd(8'hF1, 8'h00, "race_w1c");
    iKEY = 4'hF;
    cyc(8);
    wr(8'hF1, 8'h0F);
    wr(8'hF2, 8'h00);

    // Keys 2 and 1 together: lowest index recorded.
    iKEY = 4'b1001;
    cyc(6);
    rd(8'hF1, 8'h06, "simul_event");
    rd(8'hF2, 8'h81, "simul_last");
    wr(8'hF2, 8'h00);
    rd(8'hF2, 8'h00, "simul_lastclr");
    rd(8'hF1, 8'h06, "simul_evkeep");
    iKEY = 4'hF;
    cyc(8);
    wr(8'hF1, 8'h0F);
    wr(8'hF2, 8'h00);

    // Reset while key 0 held with its event set.
    iKEY = 4'b1110;
    cyc(6);
    rd(8'hF1, 8'h01, "prereset_event");
    #2;
    rst_n = 1'b0;
    rd(8'hF0, 8'h00, "async_level");
    rd(8'hF1, 8'h00, "async_event");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5);
    rd(8'hF1, 8'h00, "postreset_early");
    cyc(1);
    rd(8'hF1, 8'h01, "postreset_press");

    // Held key 0: repeat every R cycles when enabled.
    wr(8'hF1, 8'h01);
    rd(8'hF1, 8'h00, "rep_clr1");
    cyc(8);
    rd(8'hF1, 8'h00, "rep_before1");
    cyc(1);
    rd(8'hF1, rep_exp, "rep_first");
    wr(8'hF1, 8'h01);
    cyc(8);
    rd(8'hF1, 8'h00, "rep_before2");
    cyc(1);
    rd(8'hF1, rep_exp, "rep_second");

    iKEY = 4'hF;
    rd(8'h10, 8'h00, "miss_data");
    hit_chk(8'h10, 1'b0, "miss_hit");
    hit_chk(8'hF3, 1'b0, "edge_hit");
    cyc(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
